// File: rtl/xregs_master_access.sv
// xregs_master_access
//   Host-side master for the xregs slave bus. Accepts one host command at a
//   time, drives a registered request/address/write/wdata to all slaves, waits
//   for the OR'ed slave acknowledge and returns a response to the host. If no
//   acknowledge arrives within TIMEOUT wait cycles, the transaction is aborted
//   with a one-cycle abort pulse and an error response.
//
// Parameters
//   ADDR_WIDTH  word address width (default 16)
//   DATA_WIDTH  data width (default 32)
//   TIMEOUT     wait cycles before abort, legal range 2..65535 (default 255)
//
// Ports
//   clk, rst                 rising-edge clock, synchronous active-high reset
//   cmd_valid/cmd_ready      host command handshake
//   cmd_write/addr/wdata     host command fields
//   request/address/write/wdata  registered bus outputs to the slaves
//   ack_comb, rdata          OR of slave acks / read data (rdata valid with ack)
//   abort                    registered one-cycle timeout pulse to the slaves
//   rsp_valid/rsp_ready      host response handshake
//   rsp_err, rsp_rdata       timeout flag, read data (0 for writes/timeouts)
//   err_count                saturating timeout counter
module xregs_master_access #(
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned TIMEOUT    = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  output logic                  request,
  output logic [ADDR_WIDTH-1:0] address,
  output logic                  write,
  output logic [DATA_WIDTH-1:0] wdata,
  input  logic                  ack_comb,
  input  logic [DATA_WIDTH-1:0] rdata,
  output logic                  abort,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic                  rsp_err,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic [7:0]            err_count
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WAIT = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  // The counter starts at 0 on the accept edge, so the abort edge is the one
  // that samples a count of TIMEOUT-1, i.e. TIMEOUT edges after request rises.
  localparam logic [15:0] LAST_WAIT = 16'(TIMEOUT - 1);

  logic [1:0]  state;
  logic [15:0] wait_cnt;

  assign cmd_ready = (state == IDLE);
  assign rsp_valid = (state == RESP);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      wait_cnt  <= '0;
      request   <= 1'b0;
      address   <= '0;
      write     <= 1'b0;
      wdata     <= '0;
      abort     <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
      err_count <= '0;
    end else begin
      abort <= 1'b0;
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            state    <= WAIT;
            request  <= 1'b1;
            address  <= cmd_addr;
            write    <= cmd_write;
            wdata    <= cmd_wdata;
            wait_cnt <= '0;
          end
        end
        WAIT: begin
          // Ack is checked first so it wins over a coincident timeout.
          if (ack_comb) begin
            state     <= RESP;
            request   <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_rdata <= write ? '0 : rdata;
          end else if (wait_cnt == LAST_WAIT) begin
            state     <= RESP;
            request   <= 1'b0;
            abort     <= 1'b1;
            rsp_err   <= 1'b1;
            rsp_rdata <= '0;
            if (err_count != 8'hFF) begin
              err_count <= err_count + 8'd1;
            end
          end else begin
            wait_cnt <= wait_cnt + 16'd1;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            state <= IDLE;
          end
        end
        default: begin
          state   <= IDLE;
          request <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_xregs_master_access.sv
// tb_xregs_master_access
//   Two instances: u0 with TIMEOUT=8, u1 with TIMEOUT=4. A transaction-level
//   model predicts the outputs of each instance every cycle; directed
//   transactions add literal expectations for latency, data and abort timing.
module tb_xregs_master_access;

  logic        clk = 1'b0;
  logic        rst        [2];
  logic        cmd_valid  [2];
  logic        cmd_ready  [2];
  logic        cmd_write  [2];
  logic [15:0] cmd_addr   [2];
  logic [31:0] cmd_wdata  [2];
  logic        request    [2];
  logic [15:0] address    [2];
  logic        write      [2];
  logic [31:0] wdata      [2];
  logic        ack_comb   [2];
  logic [31:0] rdata      [2];
  logic        abort      [2];
  logic        rsp_valid  [2];
  logic        rsp_ready  [2];
  logic        rsp_err    [2];
  logic [31:0] rsp_rdata  [2];
  logic [7:0]  err_count  [2];

  int tmo [2] = '{8, 4};

  always #5 clk = ~clk;

  xregs_master_access #(.ADDR_WIDTH(16), .DATA_WIDTH(32), .TIMEOUT(8)) u0 (
    .clk(clk), .rst(rst[0]), .cmd_valid(cmd_valid[0]), .cmd_ready(cmd_ready[0]),
    .cmd_write(cmd_write[0]), .cmd_addr(cmd_addr[0]), .cmd_wdata(cmd_wdata[0]),
    .request(request[0]), .address(address[0]), .write(write[0]), .wdata(wdata[0]),
    .ack_comb(ack_comb[0]), .rdata(rdata[0]), .abort(abort[0]),
    .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]), .rsp_err(rsp_err[0]),
    .rsp_rdata(rsp_rdata[0]), .err_count(err_count[0])
  );

  xregs_master_access #(.ADDR_WIDTH(16), .DATA_WIDTH(32), .TIMEOUT(4)) u1 (
    .clk(clk), .rst(rst[1]), .cmd_valid(cmd_valid[1]), .cmd_ready(cmd_ready[1]),
    .cmd_write(cmd_write[1]), .cmd_addr(cmd_addr[1]), .cmd_wdata(cmd_wdata[1]),
    .request(request[1]), .address(address[1]), .write(write[1]), .wdata(wdata[1]),
    .ack_comb(ack_comb[1]), .rdata(rdata[1]), .abort(abort[1]),
    .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]), .rsp_err(rsp_err[1]),
    .rsp_rdata(rsp_rdata[1]), .err_count(err_count[1])
  );

  int n_chk  = 0;
  int n_pass = 0;
  bit mon_en = 1'b0;

  function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s actual=%0h required=%0h (t=%0t)", nm, act, exp, $time);
  endfunction

  // ---------------- transaction-level model ----------------
  // busy: a command is out on the bus; has_rsp: a response is held for the host.
  bit          m_busy   [2] = '{0, 0};
  bit          m_resp   [2] = '{0, 0};
  int          m_age    [2] = '{0, 0};
  bit          m_abort  [2] = '{0, 0};
  bit          m_wr     [2] = '{0, 0};
  logic [15:0] m_addr   [2] = '{0, 0};
  logic [31:0] m_wd     [2] = '{0, 0};
  bit          m_err    [2] = '{0, 0};
  logic [31:0] m_rd     [2] = '{0, 0};
  int          m_errcnt [2] = '{0, 0};

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      m_abort[i] = 0;
      if (rst[i]) begin
        m_busy[i] = 0; m_resp[i] = 0; m_age[i] = 0; m_wr[i] = 0;
        m_addr[i] = '0; m_wd[i] = '0; m_err[i] = 0; m_rd[i] = '0; m_errcnt[i] = 0;
      end else if (m_resp[i]) begin
        if (rsp_ready[i]) m_resp[i] = 0;
      end else if (m_busy[i]) begin
        if (ack_comb[i]) begin
          m_busy[i] = 0; m_resp[i] = 1; m_err[i] = 0;
          m_rd[i] = m_wr[i] ? 32'h0 : rdata[i];
        end else if (m_age[i] + 1 == tmo[i]) begin
          m_busy[i] = 0; m_resp[i] = 1; m_err[i] = 1; m_rd[i] = '0; m_abort[i] = 1;
          m_errcnt[i] = (m_errcnt[i] < 255) ? m_errcnt[i] + 1 : 255;
        end else begin
          m_age[i]++;
        end
      end else if (cmd_valid[i]) begin
        m_busy[i] = 1; m_age[i] = 0;
        m_wr[i] = cmd_write[i]; m_addr[i] = cmd_addr[i]; m_wd[i] = cmd_wdata[i];
      end
    end
  end

  always @(negedge clk) begin
    if (mon_en) begin
      for (int i = 0; i < 2; i++) begin
        chk($sformatf("u%0d.cmd_ready", i), cmd_ready[i], !(m_busy[i] || m_resp[i]));
        chk($sformatf("u%0d.rsp_valid", i), rsp_valid[i], m_resp[i]);
        chk($sformatf("u%0d.request", i),   request[i],   m_busy[i]);
        chk($sformatf("u%0d.abort", i),     abort[i],     m_abort[i]);
        chk($sformatf("u%0d.err_count", i), err_count[i], m_errcnt[i]);
        if (m_busy[i] || m_resp[i]) begin
          chk($sformatf("u%0d.address", i), address[i], m_addr[i]);
          chk($sformatf("u%0d.write", i),   write[i],   m_wr[i]);
          chk($sformatf("u%0d.wdata", i),   wdata[i],   m_wd[i]);
        end
        if (m_resp[i]) begin
          chk($sformatf("u%0d.rsp_err", i),   rsp_err[i],   m_err[i]);
          chk($sformatf("u%0d.rsp_rdata", i), rsp_rdata[i], m_rd[i]);
        end
      end
    end
  end

  // ---------------- directed stimulus ----------------
  typedef struct {
    int          lat;       // edges from accept edge (counted as 1) to rsp_valid
    int          abort_at;  // edges after accept edge at which abort was first seen
    int          aborts;    // cycles abort was seen high
    logic [31:0] rd;
    logic        err;
    logic        req;
    logic [15:0] addr;
    logic [31:0] wd;
  } obs_t;

  // ack_at: wait cycle index (0 = cycle right after accept) where ack_comb is
  // high; -1 = never. hold: cycles rsp_ready stays low (ack_comb junk driven).
  task automatic run_txn(input int i, input logic wr, input logic [15:0] a,
                         input logic [31:0] wd, input int ack_at, input logic [31:0] rd,
                         input int hold, output obs_t o);
    o.lat = -1; o.abort_at = -1; o.aborts = 0;
    o.rd = '0; o.err = 1'b0; o.req = 1'b0; o.addr = '0; o.wd = '0;
    @(negedge clk);
    cmd_valid[i] = 1'b1; cmd_write[i] = wr; cmd_addr[i] = a; cmd_wdata[i] = wd;
    @(posedge clk); #1;
    cmd_valid[i] = 1'b0;
    cmd_write[i] = 1'($urandom); cmd_addr[i] = 16'($urandom); cmd_wdata[i] = $urandom;
    for (int k = 0; k < 300; k++) begin
      ack_comb[i] = (k == ack_at);
      rdata[i]    = (k == ack_at) ? rd : $urandom;
      @(posedge clk); #1;
      if (abort[i]) begin
        o.aborts++;
        if (o.abort_at < 0) o.abort_at = k + 1;
      end
      if (rsp_valid[i]) begin
        o.lat = k + 2;
        o.rd = rsp_rdata[i]; o.err = rsp_err[i]; o.req = request[i];
        o.addr = address[i]; o.wd = wdata[i];
        break;
      end
    end
    ack_comb[i] = 1'b0;
    chk($sformatf("u%0d.rsp_within_bound", i), rsp_valid[i], 1'b1);
    for (int h = 0; h < hold; h++) begin
      ack_comb[i] = 1'b1; rdata[i] = $urandom;
      @(posedge clk); #1;
      if (abort[i]) o.aborts++;
    end
    ack_comb[i] = 1'b0;
    rsp_ready[i] = 1'b1;
    @(posedge clk); #1;
    if (abort[i]) o.aborts++;
    rsp_ready[i] = 1'b0;
  endtask

  initial begin
    obs_t o;
    int ab;
    for (int i = 0; i < 2; i++) begin
      rst[i] = 1'b1; cmd_valid[i] = 1'b0; cmd_write[i] = 1'b0; cmd_addr[i] = '0;
      cmd_wdata[i] = '0; ack_comb[i] = 1'b0; rdata[i] = '0; rsp_ready[i] = 1'b0;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("u%0d.reset_cmd_ready", i), cmd_ready[i], 1'b1);
      chk($sformatf("u%0d.reset_request", i),   request[i],   1'b0);
      chk($sformatf("u%0d.reset_rsp_valid", i), rsp_valid[i], 1'b0);
      chk($sformatf("u%0d.reset_err_count", i), err_count[i], 8'd0);
      rst[i] = 1'b0;
    end
    mon_en = 1'b1;

    // Read, ack one cycle after request: 3 edges counting the accept edge.
    run_txn(0, 1'b0, 16'h0004, 32'h0, 1, 32'hDEADBEEF, 0, o);
    chk("rd_latency", o.lat, 3);
    chk("rd_rdata", o.rd, 32'hDEADBEEF);
    chk("rd_err", o.err, 1'b0);
    chk("rd_request_low_at_ack", o.req, 1'b0);

    // Write, ack after 5 cycles; junk rdata on the ack must not leak.
    run_txn(0, 1'b1, 16'h0010, 32'h12345678, 5, 32'hA5A5A5A5, 0, o);
    chk("wr_latency", o.lat, 7);
    chk("wr_rdata_zero", o.rd, 32'h0);
    chk("wr_err", o.err, 1'b0);
    chk("wr_address", o.addr, 16'h0010);
    chk("wr_wdata", o.wd, 32'h12345678);

    // Response held 10 cycles with ack_comb noise in RESP.
    run_txn(0, 1'b0, 16'h0ABC, 32'h0, 2, 32'hCAFE0001, 10, o);
    chk("hold_latency", o.lat, 4);
    chk("hold_rdata", o.rd, 32'hCAFE0001);
    chk("hold_aborts", o.aborts, 0);

    // Timeout on the TIMEOUT=8 instance.
    run_txn(0, 1'b0, 16'h0100, 32'h0, -1, 32'h0, 1, o);
    chk("t8_abort_at", o.abort_at, 8);
    chk("t8_aborts", o.aborts, 1);
    chk("t8_err", o.err, 1'b1);
    chk("t8_err_count", err_count[0], 8'd1);

    // TIMEOUT=4, no ack.
    run_txn(1, 1'b0, 16'h0020, 32'h0, -1, 32'h0, 2, o);
    chk("t4_abort_at", o.abort_at, 4);
    chk("t4_aborts", o.aborts, 1);
    chk("t4_err", o.err, 1'b1);
    chk("t4_rdata", o.rd, 32'h0);
    chk("t4_err_count", err_count[1], 8'd1);

    // TIMEOUT=4, ack on the last wait cycle: ack wins.
    run_txn(1, 1'b0, 16'h0030, 32'h0, 3, 32'h0BADF00D, 0, o);
    chk("t4_ack_wins_aborts", o.aborts, 0);
    chk("t4_ack_wins_err", o.err, 1'b0);
    chk("t4_ack_wins_rdata", o.rd, 32'h0BADF00D);
    chk("t4_ack_wins_latency", o.lat, 5);
    chk("t4_ack_wins_err_count", err_count[1], 8'd1);

    // Reset in the middle of WAIT: everything clears, no abort follows.
    @(negedge clk);
    cmd_valid[1] = 1'b1; cmd_write[1] = 1'b1; cmd_addr[1] = 16'h7777; cmd_wdata[1] = 32'hFFFF0000;
    @(posedge clk); #1;
    cmd_valid[1] = 1'b0;
    @(posedge clk); #1;
    rst[1] = 1'b1;
    @(posedge clk); #1;
    rst[1] = 1'b0;
    chk("rst_request", request[1], 1'b0);
    chk("rst_abort", abort[1], 1'b0);
    chk("rst_write", write[1], 1'b0);
    chk("rst_address", address[1], 16'h0);
    chk("rst_wdata", wdata[1], 32'h0);
    chk("rst_rsp_err", rsp_err[1], 1'b0);
    chk("rst_rsp_rdata", rsp_rdata[1], 32'h0);
    chk("rst_err_count", err_count[1], 8'd0);
    chk("rst_rsp_valid", rsp_valid[1], 1'b0);
    chk("rst_cmd_ready", cmd_ready[1], 1'b1);
    ab = 0;
    repeat (8) begin
      @(posedge clk); #1;
      if (abort[1]) ab++;
    end
    chk("rst_no_abort", ab, 0);

    // 300 timeouts: err_count saturates at 255.
    for (int n = 0; n < 300; n++) begin
      run_txn(1, 1'($urandom), 16'($urandom), $urandom, -1, 32'h0, 0, o);
      if (n == 254) chk("sat_err_count_255th", err_count[1], 8'd255);
    end
    chk("sat_err_count_final", err_count[1], 8'd255);
    chk("sat_last_err", o.err, 1'b1);

    repeat (2) @(posedge clk);
    #1;
    mon_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/xregs_master_access.md
XREGS_MASTER_ACCESS -- requirements
Module: xregs_master_access

Interface
REQ-001 Parameter ADDR_WIDTH, default 16; width of the word address (not a byte address) driven to the slaves.
REQ-002 Parameter DATA_WIDTH, default 32; width of the write and read data.
REQ-003 Parameter TIMEOUT, default 255, legal range 2..65535; wait-cycle count before the transaction is aborted.
REQ-004 clk  input  1  single clock; every flop is on the rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 cmd_valid  input  1  host command present.
REQ-007 cmd_ready  output  1  command accepted when high together with cmd_valid.
REQ-008 cmd_write  input  1  1 = write, 0 = read.
REQ-009 cmd_addr  input  ADDR_WIDTH  target word address.
REQ-010 cmd_wdata  input  DATA_WIDTH  write data.
REQ-011 request  output  1  bus request to all slaves; registered.
REQ-012 address  output  ADDR_WIDTH  bus word address; registered.
REQ-013 write  output  1  bus direction; registered.
REQ-014 wdata  output  DATA_WIDTH  bus write data; registered.
REQ-015 ack_comb  input  1  OR of all slave qualified_ack signals.
REQ-016 rdata  input  DATA_WIDTH  OR of slave read data; valid only while ack_comb is high.
REQ-017 abort  output  1  one-cycle timeout pulse to the slaves; registered.
REQ-018 rsp_valid  output  1  response present.
REQ-019 rsp_ready  input  1  host accepts the response.
REQ-020 rsp_err  output  1  response is a timeout.
REQ-021 rsp_rdata  output  DATA_WIDTH  read data; 0 for writes and for timeouts.
REQ-022 err_count  output  8  saturating count of timeouts.

Function
REQ-023 The FSM SHALL have three states: IDLE, WAIT and RESP.
REQ-024 cmd_ready SHALL equal (state==IDLE); it is combinational from the state only.
REQ-025 IDLE, cmd_valid=1 SHALL cause, at the next edge: state to WAIT; request to 1; address, write and wdata loaded from cmd_*; wait counter to 0.
REQ-026 address, write and wdata SHALL stay stable from the accept edge until the edge that leaves RESP.
REQ-027 In WAIT with ack_comb=1, the next edge SHALL: clear request; capture rdata into rsp_rdata if write=0, otherwise load 0; set rsp_err to 0; set state to RESP.
REQ-028 request SHALL drop on the same edge that samples ack_comb, so that the slave does not requalify.
REQ-029 In WAIT with ack_comb=0, the wait counter (16 bits) SHALL increment by 1 per cycle.
REQ-030 In WAIT with ack_comb=0 and counter==TIMEOUT-1, the next edge SHALL: clear request; set abort to 1 for exactly one cycle; set rsp_err to 1; set rsp_rdata to 0; increment err_count unless it is at 255; set state to RESP.
REQ-031 If ack_comb and the timeout condition occur in the same cycle, the ack SHALL win and no abort is issued.
REQ-032 rsp_valid SHALL equal (state==RESP).
REQ-033 rsp_err and rsp_rdata SHALL hold while in RESP.
REQ-034 In RESP with rsp_ready=1, the next state SHALL be IDLE; the next command is accepted no earlier than one cycle later.
REQ-035 ack_comb SHALL be ignored in IDLE and RESP.
REQ-036 Minimum transaction latency SHALL be 3 edges from accept to rsp_valid, given a 1-cycle registered slave qualify.
REQ-037 Throughput SHALL be at most one transaction in flight.

Reset
REQ-038 rst=1 at an edge SHALL force, from any state including mid-transaction: state IDLE; request, abort, write, rsp_err = 0; address, wdata, rsp_rdata = 0; wait counter and err_count = 0.
REQ-039 No abort SHALL be issued for a transaction killed by reset.

Verification
REQ-040 Read of 16'h0004, slave acks 1 cycle after request, rdata=32'hDEADBEEF -> rsp_valid 3 edges after accept, rsp_rdata=32'hDEADBEEF, rsp_err=0, request low on the ack edge.
REQ-041 Write to 16'h0010 with wdata 32'h12345678, ack after 5 cycles -> rsp_rdata=0, rsp_err=0, address and wdata stable throughout.
REQ-042 TIMEOUT=4, no ack -> abort high exactly one cycle, 4 cycles after request rises; rsp_err=1; err_count=1.
REQ-043 TIMEOUT=4, ack_comb first high on the 4th wait cycle -> ack wins, abort stays 0, rsp_err=0.
REQ-044 rsp_ready held low 10 cycles -> rsp_valid and rsp_rdata stable; cmd_ready=0 throughout.
REQ-045 rst asserted in WAIT, then 300 forced timeouts -> all outputs 0 after reset with no abort; err_count saturates at 255.
